histogram_axi_reader: RTL and testbench

AXI4-Lite read master that fetches a complete luminance histogram from the histogram AXI slave on the MicroBlaze clock domain. On a start pulse it walks every bin with single-beat reads and emits a per-bin stream carrying the running cumulative sum (CDF). It also produces frame statistics: total pixel count, peak bin and error flag. It sits beside the histogram slave and feeds the contrast/equalisation logic without CPU involvement.

---
 rtl/histogram_axi_reader_pkg.sv | 34 +++
 rtl/hist_stats_acc.sv | 73 +++++++
 rtl/histogram_axi_reader.sv | 185 ++++++++++++++++++
 tb/tb_histogram_axi_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_axi_reader_pkg.sv
// -----------------------------------------------------------------------------
// hist_pkg
// Shared definitions for the histogram AXI4-Lite reader:
//   - hist_state_e : sweep FSM state encoding (also exported for debug)
//   - RESP_*       : AXI read response codes
//   - DEFAULT_NUM_BINS, CDF_MAX, WD_LIMIT : sizing constants
//   - resp_is_err(): any response other than OKAY is treated as an error
// -----------------------------------------------------------------------------
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } hist_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int          DEFAULT_NUM_BINS = 256;
  localparam logic [31:0] CDF_MAX          = 32'hFFFF_FFFF;

  // Watchdog terminal count (only used when HIST_READER_TIMEOUT_EN is defined)
  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

  // EXOKAY is not meaningful for AXI4-Lite, so everything but OKAY is an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/hist_stats_acc.sv
// -----------------------------------------------------------------------------
// hist_stats_acc
// Running statistics for one histogram sweep: saturating cumulative sum (CDF)
// and peak-bin tracker. One bin is folded in per en_i pulse.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           clear CDF and peak (start of a sweep); wins over en_i
//   en_i            accumulate data_i as bin idx_i
//   data_i [31:0]   bin value
//   idx_i  [7:0]    bin index of data_i
//   cdf_o  [31:0]   saturating sum of all accumulated bins
//   max_count_o     largest bin value seen (strictly-greater update)
//   max_idx_o       index of that bin (lowest index wins on ties)
//   sat_o           combinational: the add performed this cycle overflowed
// -----------------------------------------------------------------------------
module hist_stats_acc
  import hist_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  idx_i,
  output logic [31:0] cdf_o,
  output logic [31:0] max_count_o,
  output logic [7:0]  max_idx_o,
  output logic        sat_o
);

  logic [31:0] cdf_q, cdf_d;
  logic [31:0] max_count_q, max_count_d;
  logic [7:0]  max_idx_q, max_idx_d;
  logic [32:0] sum;

  always_comb begin
    sum         = {1'b0, cdf_q} + {1'b0, data_i};
    sat_o       = en_i & ~clr_i & sum[32];
    cdf_d       = cdf_q;
    max_count_d = max_count_q;
    max_idx_d   = max_idx_q;
    if (clr_i) begin
      cdf_d       = '0;
      max_count_d = '0;
      max_idx_d   = '0;
    end else if (en_i) begin
      cdf_d = sum[32] ? CDF_MAX : sum[31:0];
      // Strictly greater keeps the lowest index on ties.
      if (data_i > max_count_q) begin
        max_count_d = data_i;
        max_idx_d   = idx_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cdf_q       <= '0;
      max_count_q <= '0;
      max_idx_q   <= '0;
    end else begin
      cdf_q       <= cdf_d;
      max_count_q <= max_count_d;
      max_idx_q   <= max_idx_d;
    end
  end

  assign cdf_o       = cdf_q;
  assign max_count_o = max_count_q;
  assign max_idx_o   = max_idx_q;

endmodule

// File: rtl/histogram_axi_reader.sv
// -----------------------------------------------------------------------------
// histogram_axi_reader
// AXI4-Lite read master that sweeps every bin of the histogram slave with
// single-beat reads, streams each bin with its running CDF, and reports the
// sweep total, peak bin and a sticky error flag.
//
// Optional feature: define HIST_READER_TIMEOUT_EN to enable a 16-bit watchdog
// that abandons a read stuck in ADDR/DATA, emits that bin as 0 and sets err.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. arvalid, once high, stays high with a stable araddr until
// arready (or a watchdog abort); rready is high only while waiting for data,
// so rvalid at any other time is never accepted. One transaction in flight.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start                         sweep request (accepted only when idle)
//   busy, done                    sweep in progress / one-cycle completion
//   m_axi_ar*, m_axi_r*           AXI4-Lite read address and data channels
//   bin_valid, bin_idx,
//   bin_count, bin_cdf            per-bin output stream (registered)
//   total, max_idx, max_count     sweep statistics, valid from done to start
//   err                           sticky error, cleared on start
//   dbg_state                     current FSM state
// -----------------------------------------------------------------------------
module histogram_axi_reader
  import hist_pkg::*;
#(
  parameter int          ADDR_BITS = 10,
  parameter int          NUM_BINS  = DEFAULT_NUM_BINS,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  output logic                 bin_valid,
  output logic [7:0]           bin_idx,
  output logic [31:0]          bin_count,
  output logic [31:0]          bin_cdf,
  output logic [31:0]          total,
  output logic [7:0]           max_idx,
  output logic [31:0]          max_count,
  output logic                 err,
  output hist_state_e          dbg_state
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_BINS - 1);

  hist_state_e state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] bin_count_q, bin_count_d;
  logic        err_q, err_d;

  logic        ar_hs, r_hs, wd_expired, timeout_hit;
  logic        start_acc, capture, cap_err, last_bin;
  logic [31:0] cap_data;
  logic [31:0] acc_cdf, acc_max_count;
  logic [7:0]  acc_max_idx;
  logic        acc_sat;

  assign ar_hs     = (state_q == ST_ADDR) & m_axi_arready;
  assign r_hs      = (state_q == ST_DATA) & m_axi_rvalid;
  assign start_acc = (state_q == ST_IDLE) & start;
  assign last_bin  = (idx_q == LAST_IDX);

`ifdef HIST_READER_TIMEOUT_EN
  // Counts every cycle of one bin's ADDR+DATA wait; cleared outside them.
  logic [15:0] wd_q, wd_d;
  logic        in_wait;

  assign in_wait    = (state_q == ST_ADDR) | (state_q == ST_DATA);
  assign wd_d       = in_wait ? wd_q + 16'd1 : '0;
  assign wd_expired = in_wait & (wd_q == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  // A handshake landing on the expiry cycle still completes normally.
  assign timeout_hit = wd_expired & ~ar_hs & ~r_hs;

  // Error responses and aborted reads contribute a zero bin.
  assign capture  = r_hs | timeout_hit;
  assign cap_err  = timeout_hit | (r_hs & resp_is_err(m_axi_rresp));
  assign cap_data = (r_hs & ~resp_is_err(m_axi_rresp)) ? m_axi_rdata : '0;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_ADDR;
      ST_ADDR: begin
        if (ar_hs)            state_d = ST_DATA;
        else if (timeout_hit) state_d = ST_EMIT;
      end
      ST_DATA: if (r_hs | timeout_hit) state_d = ST_EMIT;
      ST_EMIT: state_d = last_bin ? ST_DONE : ST_ADDR;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    m_axi_arvalid = (state_q == ST_ADDR);
    m_axi_rready  = (state_q == ST_DATA);
    bin_valid     = (state_q == ST_EMIT);
    // Address is forced to 0 outside ADDR so every output idles at 0.
    m_axi_araddr  = '0;
    if (state_q == ST_ADDR)
      m_axi_araddr = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'({idx_q, 2'b00});
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    idx_d       = idx_q;
    bin_count_d = bin_count_q;
    err_d       = err_q;
    if (start_acc) begin
      idx_d = '0;
      err_d = 1'b0;
    end
    if (capture) begin
      bin_count_d = cap_data;
      if (cap_err) err_d = 1'b1;
    end
    if (acc_sat) err_d = 1'b1;
    if ((state_q == ST_EMIT) && !last_bin) idx_d = idx_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      bin_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      bin_count_q <= bin_count_d;
      err_q       <= err_d;
    end
  end

  hist_stats_acc u_stats (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_i       (start_acc),
    .en_i        (capture),
    .data_i      (cap_data),
    .idx_i       (idx_q),
    .cdf_o       (acc_cdf),
    .max_count_o (acc_max_count),
    .max_idx_o   (acc_max_idx),
    .sat_o       (acc_sat)
  );

  assign bin_idx   = idx_q;
  assign bin_count = bin_count_q;
  assign bin_cdf   = acc_cdf;
  // The CDF after the last bin is the sweep total.
  assign total     = acc_cdf;
  assign max_idx   = acc_max_idx;
  assign max_count = acc_max_count;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_histogram_axi_reader.sv
// -----------------------------------------------------------------------------
// tb_histogram_axi_reader
// Directed bench for histogram_axi_reader: an AXI4-Lite slave model with
// optional random wait states, a bin-stream scoreboard, and directed sweeps
// (ramp, random waits, error responses, CDF saturation, all-zero, mid-sweep
// reset, and the watchdog when HIST_READER_TIMEOUT_EN is defined).
// -----------------------------------------------------------------------------
module tb_histogram_axi_reader;
  import hist_pkg::*;

  localparam int          ADDR_BITS = 11;
  localparam int          NUM_BINS  = 256;
  localparam int unsigned BASE_ADDR = 256;

  // ------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic                 busy, done;
  logic [ADDR_BITS-1:0] m_axi_araddr;
  logic                 m_axi_arvalid;
  logic                 m_axi_arready = 1'b0;
  logic [31:0]          m_axi_rdata   = '0;
  logic [1:0]           m_axi_rresp   = '0;
  logic                 m_axi_rvalid  = 1'b0;
  logic                 m_axi_rready;
  logic                 bin_valid;
  logic [7:0]           bin_idx;
  logic [31:0]          bin_count, bin_cdf, total, max_count;
  logic [7:0]           max_idx;
  logic                 err;
  hist_state_e          dbg_state;

  histogram_axi_reader #(
    .ADDR_BITS (ADDR_BITS),
    .NUM_BINS  (NUM_BINS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .bin_valid     (bin_valid),
    .bin_idx       (bin_idx),
    .bin_count     (bin_count),
    .bin_cdf       (bin_cdf),
    .total         (total),
    .max_idx       (max_idx),
    .max_count     (max_count),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // ------------------------------------------------------- bookkeeping
  int n_assert = 0;
  int n_fail   = 0;
  int strobes  = 0;
  logic [71:0] exp_q[$];   // {idx[7:0], count[31:0], cdf[31:0]}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ------------------------------------------------------- slave behaviour
  int sl_mode   = 0;    // 0 ramp, 1 ramp+SLVERR@10+DECERR@200, 2 saturate, 3 zeros
  bit sl_rand   = 1'b0;
  int sl_to_bin = -1;   // bin whose address is never accepted
  int sl_next   = 0;
  int sl_st     = 0;
  int sl_cnt    = 0;
  int sl_bin    = 0;
  logic [ADDR_BITS-1:0] sl_addr = '0;

  function automatic logic [31:0] sl_data(input int i);
    case (sl_mode)
      0, 1:    return 32'(i);
      2:       return (i < 2) ? 32'h8000_0000 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] sl_resp(input int i);
    if (sl_mode == 1 && i == 10)  return RESP_SLVERR;
    if (sl_mode == 1 && i == 200) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic int sl_delay();
    return sl_rand ? int'($urandom_range(0, 7)) : 0;
  endfunction

  // Expected bin stream for the current slave settings.
  task automatic build_expect();
    logic [31:0] cdf;
    logic [31:0] c;
    logic [32:0] s;
    exp_q.delete();
    cdf = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      c = (sl_resp(i) != RESP_OKAY || i == sl_to_bin) ? 32'h0 : sl_data(i);
      s = {1'b0, cdf} + {1'b0, c};
      cdf = s[32] ? 32'hFFFF_FFFF : s[31:0];
      exp_q.push_back({8'(i), c, cdf});
    end
  endtask

  // Slave acts on falling edges. With zero extra delay arready follows
  // arvalid by one cycle and rvalid is offered on the first rready cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        sl_st = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
      end else begin
        case (sl_st)
          0: if (m_axi_arvalid) begin
            check("araddr_seq", 32'(m_axi_araddr), 32'(BASE_ADDR) + 32'(4 * sl_next));
            sl_addr = m_axi_araddr;
            sl_bin  = sl_next;
            sl_next++;
            sl_cnt  = sl_delay();
            sl_st   = 1;
          end
          1: begin
            if (sl_bin == sl_to_bin) begin
              if (!m_axi_arvalid) sl_st = 0;
            end else begin
              check("arvalid_held", 32'(m_axi_arvalid), 32'd1);
              check("araddr_stable", 32'(m_axi_araddr), 32'(sl_addr));
              if (sl_cnt == 0) begin
                m_axi_arready = 1'b1;
                sl_st = 2;
              end else sl_cnt--;
            end
          end
          2: begin
            // AR handshake took place on the preceding rising edge.
            m_axi_arready = 1'b0;
            check("rready_after_ar", 32'(m_axi_rready), 32'd1);
            sl_cnt = sl_delay();
            if (sl_cnt == 0) begin
              m_axi_rvalid = 1'b1;
              m_axi_rdata  = sl_data(sl_bin);
              m_axi_rresp  = sl_resp(sl_bin);
              sl_st = 4;
            end else sl_st = 3;
          end
          3: begin
            check("rready_held", 32'(m_axi_rready), 32'd1);
            sl_cnt--;
            if (sl_cnt == 0) begin
              m_axi_rvalid = 1'b1;
              m_axi_rdata  = sl_data(sl_bin);
              m_axi_rresp  = sl_resp(sl_bin);
              sl_st = 4;
            end
          end
          default: begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rresp  = RESP_OKAY;
            check("bin_valid_after_r", 32'(bin_valid), 32'd1);
            sl_st = 0;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------- stream scoreboard
  always @(negedge clk) begin : mon
    logic [71:0] e;
    if (rst && bin_valid) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("bin_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("bin_idx", 32'(bin_idx), 32'(e[71:64]));
        check("bin_count", bin_count, e[63:32]);
        check("bin_cdf", bin_cdf, e[31:0]);
      end
    end
  end

  // ------------------------------------------------------- driver tasks
  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_arvalid"},   32'(m_axi_arvalid), 32'd0);
    check({tag, "_araddr"},    32'(m_axi_araddr), 32'd0);
    check({tag, "_rready"},    32'(m_axi_rready), 32'd0);
    check({tag, "_bin_valid"}, 32'(bin_valid), 32'd0);
    check({tag, "_bin_idx"},   32'(bin_idx), 32'd0);
    check({tag, "_bin_count"}, bin_count, 32'd0);
    check({tag, "_bin_cdf"},   bin_cdf, 32'd0);
    check({tag, "_total"},     total, 32'd0);
    check({tag, "_max_idx"},   32'(max_idx), 32'd0);
    check({tag, "_max_count"}, max_count, 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
    check({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic set_slave(input int mode, input bit rnd, input int to_bin);
    sl_mode   = mode;
    sl_rand   = rnd;
    sl_to_bin = to_bin;
    sl_next   = 0;
    strobes   = 0;
    build_expect();
  endtask

  // Full sweep. With a zero-wait slave the start cycle is cycle 0 and done
  // lands on cycle 4*NUM_BINS+1, so the sweep spans 4*NUM_BINS+2 cycles.
  task automatic do_sweep(input string tag, input int mode, input bit rnd, input int to_bin,
                          input bit timed, input logic [31:0] e_total,
                          input logic [7:0] e_max_idx, input logic [31:0] e_max_count,
                          input logic e_err);
    int cyc;
    set_slave(mode, rnd, to_bin);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    check({tag, "_busy_c1"},    32'(busy), 32'd1);
    check({tag, "_arvalid_c1"}, 32'(m_axi_arvalid), 32'd1);
    check({tag, "_araddr_c1"},  32'(m_axi_araddr), 32'(BASE_ADDR));
    check({tag, "_err_clr"},    32'(err), 32'd0);
    while (!done && cyc < 200000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (timed) check({tag, "_done_cycle"}, 32'(cyc), 32'(4 * NUM_BINS + 1));
    // A start coinciding with done must be ignored.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_done_pulse"},   32'(done), 32'd0);
    check({tag, "_busy_fall"},    32'(busy), 32'd0);
    check({tag, "_start_at_done"}, 32'(m_axi_arvalid), 32'd0);
    check({tag, "_strobes"},      32'(strobes), 32'(NUM_BINS));
    check({tag, "_exp_left"},     32'(exp_q.size()), 32'd0);
    check({tag, "_total"},        total, e_total);
    check({tag, "_max_idx"},      32'(max_idx), 32'(e_max_idx));
    check({tag, "_max_count"},    max_count, e_max_count);
    check({tag, "_err"},          32'(err), 32'(e_err));
  endtask

  // ------------------------------------------------------- directed steps
  initial begin
    int cyc;

    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Ramp 0..255, zero wait: sum 32640, peak at bin 255
    do_sweep("ramp", 0, 1'b0, -1, 1'b1, 32'd32640, 8'd255, 32'd255, 1'b0);

    // Same data with random 0-7 cycle waits on both channels
    do_sweep("ramp_rand", 0, 1'b1, -1, 1'b0, 32'd32640, 8'd255, 32'd255, 1'b0);

    // SLVERR on bin 10, DECERR on bin 200: 32640-10-200 = 32430
    do_sweep("resp_err", 1, 1'b0, -1, 1'b1, 32'd32430, 8'd255, 32'd255, 1'b1);

    // Bins 0 and 1 = 0x8000_0000: saturates on bin 1, tie keeps bin 0
    do_sweep("saturate", 2, 1'b0, -1, 1'b1, 32'hFFFF_FFFF, 8'd0, 32'h8000_0000, 1'b1);

    // All-zero histogram (also shows err cleared by start)
    do_sweep("zeros", 3, 1'b0, -1, 1'b1, 32'd0, 8'd0, 32'd0, 1'b0);

    // Reset while waiting for bin 50 data
    set_slave(0, 1'b0, -1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(m_axi_rready && bin_idx == 8'd50) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reach_bin50", {23'd0, m_axi_rready, bin_idx}, {23'd0, 1'b1, 8'd50});
    rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    do_sweep("after_rst", 0, 1'b0, -1, 1'b1, 32'd32640, 8'd255, 32'd255, 1'b0);

`ifdef HIST_READER_TIMEOUT_EN
    // Bin 3 address never accepted: watchdog emits it as 0 and moves on
    do_sweep("timeout", 0, 1'b0, 3, 1'b0, 32'd32637, 8'd255, 32'd255, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
